parking_gate_arbiter: RTL and testbench
=======================================

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameter: CAPACITY, 8, maximum number of parked cars (2..15).
REQ-002 Parameter: OPEN_TIME, 5, clock cycles the gate stays open waiting for a car before timing out (>=2).
REQ-003 Port: clk_1Hz  input  1  system clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: entry_req  input  1  level request from entry sensor; held until entry_grant.
REQ-006 Port: exit_req  input  1  level request from exit sensor; held until exit_grant.
REQ-007 Port: pass  input  1  car has cleared the gate; one-cycle pulse.
REQ-008 Port: gate_open  output  1  gate actuator, 1 = open.
REQ-009 Port: entry_grant  output  1  one-cycle pulse, entry served.
REQ-010 Port: exit_grant  output  1  one-cycle pulse, exit served.
REQ-011 Port: count  output  4  current occupancy.
REQ-012 Port: full_signal  output  1  level, count == CAPACITY; drives the full-LED block.
REQ-013 Port: empty_signal  output  1  level, count == 0.
REQ-014 Port: timeout  output  1  one-cycle pulse, gate closed without a pass.

Function
REQ-015 The block SHALL be a registered FSM with states IDLE, ENTRY_OPEN, EXIT_OPEN, HOLDOFF; every output SHALL be a register or decoded only from registered state/count.
REQ-016 Eligibility: entry SHALL be eligible only if entry_req=1 and count<CAPACITY; exit only if exit_req=1 and count>0.
REQ-017 IDLE, exactly one eligible: next edge -> matching *_OPEN state; gate_open=1 and the matching grant=1 for that first open cycle only.
REQ-018 IDLE, both eligible: the direction opposite last_served SHALL win; last_served updates on every grant.
REQ-019 IDLE, none eligible: remain IDLE; ineligible requests SHALL NOT be granted or queued (entry while full simply waits).
REQ-020 *_OPEN: an internal timer SHALL count cycles from 0 on entry to the state; requests SHALL be ignored.
REQ-021 *_OPEN with pass=1: next edge -> HOLDOFF, gate_open=0, count +1 (ENTRY_OPEN) or -1 (EXIT_OPEN).
REQ-022 *_OPEN, pass=0, timer == OPEN_TIME-1: next edge -> HOLDOFF, gate_open=0, timeout=1 for one cycle, count unchanged.
REQ-023 pass and timer expiry in the same cycle: pass SHALL take precedence; no timeout pulse.
REQ-024 HOLDOFF SHALL last exactly one cycle with gate closed, then -> IDLE; pass SHALL be ignored in IDLE and HOLDOFF.
REQ-025 Latency: request sampled in cycle N -> gate_open in N+1; pass in cycle M -> count update and gate closed in M+1; earliest next grant M+3.
REQ-026 count SHALL never exceed CAPACITY or wrap below 0; full_signal/empty_signal SHALL change in the same cycle as count.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, count=0, timer=0, last_served=exit, gate_open=0, both grants=0, timeout=0, full_signal=0, empty_signal=1, regardless of state.
REQ-028 Reset mid-open SHALL close the gate on the same edge and discard the in-progress transaction; no count change, no timeout pulse.
REQ-029 While reset=1, requests and pass SHALL be ignored.

Verification (bench uses CAPACITY=3, OPEN_TIME=4)
REQ-030 Single entry: entry_req in IDLE, pass 2 cycles after grant -> entry_grant pulse 1 cycle, gate_open 2 cycles, count 0->1, empty_signal 1->0.
REQ-031 Fill and block: 3 entries with pass -> count=3, full_signal=1; 4th entry_req held 10 cycles -> no grant, gate_open stays 0.
REQ-032 Tie arbitration: count=1, entry_req and exit_req both held -> grant order entry, exit, entry (first tie to entry after reset), with one HOLDOFF cycle between transactions.
REQ-033 Timeout: exit_req at count=2, no pass -> gate_open exactly 4 cycles, timeout pulse on close, count stays 2; pass on the final open cycle instead -> count 1, no timeout.
REQ-034 Exit when empty: count=0, exit_req held -> no grant, empty_signal=1.
REQ-035 Reset mid-open: reset asserted during ENTRY_OPEN at count=2 -> next edge gate_open=0, count=0, full_signal=0, empty_signal=1, no grant or timeout pulses.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// Purpose: single-gate car park arbiter; serves entry/exit requests and tracks occupancy.
// Latency: request sampled N -> gate open N+1; pass at M -> count/close M+1, next grant M+3.
// Backpressure: requests are level-held; ineligible ones (full/empty) simply wait, never queued.
module parking_gate_arbiter #(
    parameter int unsigned CAPACITY  = 8,
    parameter int unsigned OPEN_TIME = 5
) (
    input  logic       clk_1Hz,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       pass,
    output logic       gate_open,
    output logic       entry_grant,
    output logic       exit_grant,
    output logic [3:0] count,
    output logic       full_signal,
    output logic       empty_signal,
    output logic       timeout
);

    localparam int TW = (OPEN_TIME > 2) ? $clog2(OPEN_TIME) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(OPEN_TIME - 1);
    localparam logic [3:0]    CAP        = 4'(CAPACITY);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2,
        HOLDOFF    = 2'd3
    } state_t;

    typedef enum logic {
        DIR_ENTRY = 1'b0,
        DIR_EXIT  = 1'b1
    } dir_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      count_d;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    dir_t            last_q;
    dir_t            last_d;
    logic            entry_grant_d;
    logic            exit_grant_d;
    logic            timeout_d;
    logic            entry_ok;
    logic            exit_ok;

    assign entry_ok = entry_req && (count < CAP);
    assign exit_ok  = exit_req && (count != 4'd0);

    always_comb begin
        state_d       = state_q;
        count_d       = count;
        timer_d       = timer_q;
        last_d        = last_q;
        entry_grant_d = 1'b0;
        exit_grant_d  = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                // On a tie, the direction not served last time wins.
                if (entry_ok && (!exit_ok || (last_q == DIR_EXIT))) begin
                    state_d       = ENTRY_OPEN;
                    entry_grant_d = 1'b1;
                    last_d        = DIR_ENTRY;
                end else if (exit_ok) begin
                    state_d      = EXIT_OPEN;
                    exit_grant_d = 1'b1;
                    last_d       = DIR_EXIT;
                end
            end

            ENTRY_OPEN, EXIT_OPEN: begin
                // A pass on the last open cycle still counts; it beats the timeout.
                if (pass) begin
                    state_d = HOLDOFF;
                    timer_d = '0;
                    if (state_q == ENTRY_OPEN) begin
                        if (count < CAP) begin
                            count_d = count + 4'd1;
                        end
                    end else begin
                        if (count != 4'd0) begin
                            count_d = count - 4'd1;
                        end
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = HOLDOFF;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            HOLDOFF: begin
                state_d = IDLE;
                timer_d = '0;
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            state_q     <= IDLE;
            count       <= 4'd0;
            timer_q     <= '0;
            last_q      <= DIR_EXIT;
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count       <= count_d;
            timer_q     <= timer_d;
            last_q      <= last_d;
            entry_grant <= entry_grant_d;
            exit_grant  <= exit_grant_d;
            timeout     <= timeout_d;
        end
    end

    assign gate_open    = (state_q == ENTRY_OPEN) || (state_q == EXIT_OPEN);
    assign full_signal  = (count == CAP);
    assign empty_signal = (count == 4'd0);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with CAPACITY=3, OPEN_TIME=4.
module tb_parking_gate_arbiter;

    localparam int CAP = 3;
    localparam int OT  = 4;

    logic       clk_1Hz = 1'b0;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic       pass;
    logic       gate_open;
    logic       entry_grant;
    logic       exit_grant;
    logic [3:0] count;
    logic       full_signal;
    logic       empty_signal;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    parking_gate_arbiter #(.CAPACITY(CAP), .OPEN_TIME(OT)) dut (
        .clk_1Hz      (clk_1Hz),
        .reset        (reset),
        .entry_req    (entry_req),
        .exit_req     (exit_req),
        .pass         (pass),
        .gate_open    (gate_open),
        .entry_grant  (entry_grant),
        .exit_grant   (exit_grant),
        .count        (count),
        .full_signal  (full_signal),
        .empty_signal (empty_signal),
        .timeout      (timeout)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic step();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; pass = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Drives one request and observes the transaction; pass_at = open cycle (1 = grant cycle) carrying pass, 0 = none.
    task automatic run_txn(input bit is_entry, input int pass_at, output bit granted,
                           output int open_cycles, output int timeouts, output int wrong_grants);
        granted = 1'b0; open_cycles = 0; timeouts = 0; wrong_grants = 0;
        if (is_entry) entry_req = 1'b1; else exit_req = 1'b1;
        for (int i = 0; i < 20 && !granted; i++) begin
            step();
            if ((is_entry ? entry_grant : exit_grant) === 1'b1) granted = 1'b1;
            if ((is_entry ? exit_grant : entry_grant) === 1'b1) wrong_grants++;
        end
        entry_req = 1'b0; exit_req = 1'b0;
        if (granted) begin
            for (int k = 1; k <= 20; k++) begin
                if (gate_open !== 1'b1) break;
                open_cycles++;
                pass = (k == pass_at);
                step();
                pass = 1'b0;
                if (timeout === 1'b1) timeouts++;
                if (entry_grant === 1'b1 || exit_grant === 1'b1) wrong_grants++;
            end
            step();
            if (timeout === 1'b1) timeouts++;
        end
    endtask

    task automatic test_reset();
        entry_req = 1'b1; exit_req = 1'b1; pass = 1'b1; reset = 1'b1;
        step();
        step();
        n_checks++; if (gate_open !== 1'b0)    begin n_fail++; $display("FAIL reset_gate_open got=%b exp=0", gate_open); end
        n_checks++; if (count !== 4'd0)        begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (empty_signal !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty_signal); end
        n_checks++; if (full_signal !== 1'b0)  begin n_fail++; $display("FAIL reset_full got=%b exp=0", full_signal); end
        n_checks++; if ({entry_grant, exit_grant, timeout} !== 3'b000)
            begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {entry_grant, exit_grant, timeout}); end
        entry_req = 1'b0; exit_req = 1'b0; pass = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_entry();
        apply_reset();
        entry_req = 1'b1;
        step();
        n_checks++; if (entry_grant !== 1'b1) begin n_fail++; $display("FAIL single_grant got=%b exp=1", entry_grant); end
        n_checks++; if (gate_open !== 1'b1)   begin n_fail++; $display("FAIL single_open1 got=%b exp=1", gate_open); end
        n_checks++; if (count !== 4'd0)       begin n_fail++; $display("FAIL single_count_open got=%0d exp=0", count); end
        entry_req = 1'b0;
        step();
        n_checks++; if ({entry_grant, gate_open} !== 2'b01)
            begin n_fail++; $display("FAIL single_open2 got grant,open=%b exp=01", {entry_grant, gate_open}); end
        pass = 1'b1;
        step();
        pass = 1'b0;
        n_checks++; if (gate_open !== 1'b0)   begin n_fail++; $display("FAIL single_close got=%b exp=0", gate_open); end
        n_checks++; if (count !== 4'd1)       begin n_fail++; $display("FAIL single_count got=%0d exp=1", count); end
        n_checks++; if (empty_signal !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%b exp=0", empty_signal); end
        n_checks++; if (timeout !== 1'b0)     begin n_fail++; $display("FAIL single_timeout got=%b exp=0", timeout); end
        step();
    endtask

    task automatic test_fill_and_block();
        bit g; int oc, to, wg, bad;
        apply_reset();
        for (int n = 0; n < CAP; n++) begin
            run_txn(1'b1, 1, g, oc, to, wg);
            n_checks++; if (g !== 1'b1 || wg != 0)
                begin n_fail++; $display("FAIL fill_grant_%0d got granted=%b wrong=%0d exp granted=1 wrong=0", n, g, wg); end
        end
        n_checks++; if (count !== 4'd3)      begin n_fail++; $display("FAIL fill_count got=%0d exp=3", count); end
        n_checks++; if (full_signal !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b exp=1", full_signal); end
        bad = 0;
        entry_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (entry_grant !== 1'b0 || gate_open !== 1'b0) bad++;
        end
        entry_req = 1'b0;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL full_block got=%0d bad cycles exp=0", bad); end
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL full_count_hold got=%0d exp=3", count); end
    endtask

    task automatic test_exit_empty();
        int bad;
        apply_reset();
        bad = 0;
        exit_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (exit_grant !== 1'b0 || gate_open !== 1'b0 || empty_signal !== 1'b1) bad++;
        end
        exit_req = 1'b0;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL empty_block got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_timeout();
        bit g; int oc, to, wg;
        apply_reset();
        run_txn(1'b1, 1, g, oc, to, wg);
        run_txn(1'b1, 1, g, oc, to, wg);
        n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL to_setup_count got=%0d exp=2", count); end
        run_txn(1'b0, 0, g, oc, to, wg);
        n_checks++; if (g !== 1'b1)  begin n_fail++; $display("FAIL to_grant got=%b exp=1", g); end
        n_checks++; if (oc != OT)    begin n_fail++; $display("FAIL to_open_cycles got=%0d exp=%0d", oc, OT); end
        n_checks++; if (to != 1)     begin n_fail++; $display("FAIL to_pulse got=%0d pulses exp=1", to); end
        n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL to_count got=%0d exp=2", count); end
        run_txn(1'b0, OT, g, oc, to, wg);
        n_checks++; if (oc != OT)    begin n_fail++; $display("FAIL late_pass_open got=%0d exp=%0d", oc, OT); end
        n_checks++; if (to != 0)     begin n_fail++; $display("FAIL late_pass_timeout got=%0d pulses exp=0", to); end
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL late_pass_count got=%0d exp=1", count); end
    endtask

    task automatic test_tie();
        bit g; int oc, to, wg, ng;
        bit order [3];
        int cyc [3];
        apply_reset();
        run_txn(1'b1, 1, g, oc, to, wg);
        run_txn(1'b1, 1, g, oc, to, wg);
        run_txn(1'b0, 1, g, oc, to, wg);
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL tie_setup_count got=%0d exp=1", count); end
        ng = 0;
        entry_req = 1'b1; exit_req = 1'b1;
        for (int i = 0; i < 40 && ng < 3; i++) begin
            step();
            pass = 1'b0;
            if (entry_grant === 1'b1 || exit_grant === 1'b1) begin
                order[ng] = (exit_grant === 1'b1);
                cyc[ng]   = i;
                ng++;
                pass = 1'b1;
            end
        end
        entry_req = 1'b0; exit_req = 1'b0;
        step();
        pass = 1'b0;
        n_checks++; if (ng != 3) begin n_fail++; $display("FAIL tie_grants got=%0d exp=3", ng); end
        if (ng == 3) begin
            n_checks++; if ({order[0], order[1], order[2]} !== 3'b010)
                begin n_fail++; $display("FAIL tie_order got=%b exp=010 (0=entry)", {order[0], order[1], order[2]}); end
            n_checks++; if (cyc[1] - cyc[0] != 3 || cyc[2] - cyc[1] != 3)
                begin n_fail++; $display("FAIL tie_spacing got=%0d,%0d exp=3,3", cyc[1] - cyc[0], cyc[2] - cyc[1]); end
        end
        n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL tie_count got=%0d exp=2", count); end
        step();
    endtask

    task automatic test_reset_mid_open();
        bit g; int oc, to, wg;
        apply_reset();
        run_txn(1'b1, 1, g, oc, to, wg);
        run_txn(1'b1, 1, g, oc, to, wg);
        entry_req = 1'b1;
        step();
        n_checks++; if ({entry_grant, gate_open} !== 2'b11)
            begin n_fail++; $display("FAIL rst_mid_setup got grant,open=%b exp=11", {entry_grant, gate_open}); end
        reset = 1'b1; pass = 1'b1;
        step();
        n_checks++; if (gate_open !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_gate got=%b exp=0", gate_open); end
        n_checks++; if (count !== 4'd0)        begin n_fail++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
        n_checks++; if ({full_signal, empty_signal} !== 2'b01)
            begin n_fail++; $display("FAIL rst_mid_flags got full,empty=%b exp=01", {full_signal, empty_signal}); end
        n_checks++; if ({entry_grant, exit_grant, timeout} !== 3'b000)
            begin n_fail++; $display("FAIL rst_mid_pulses got=%b exp=000", {entry_grant, exit_grant, timeout}); end
        step();
        n_checks++; if ({gate_open, entry_grant, count} !== {2'b00, 4'd0})
            begin n_fail++; $display("FAIL rst_hold_ignore got open=%b grant=%b count=%0d exp 0,0,0", gate_open, entry_grant, count); end
        reset = 1'b0; entry_req = 1'b0; pass = 1'b0;
        step();
        n_checks++; if ({timeout, gate_open} !== 2'b00)
            begin n_fail++; $display("FAIL rst_after got timeout,open=%b exp=00", {timeout, gate_open}); end
    endtask

    initial begin
        reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; pass = 1'b0;
        test_reset();
        test_single_entry();
        test_fill_and_block();
        test_exit_empty();
        test_timeout();
        test_tie();
        test_reset_mid_open();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
